// File: rtl/mul_unit.sv
// mul_unit: multi-cycle RV32M radix-2 shift-add multiplier (MUL/MULH/MULHSU/MULHU).
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, lo_q, lo_d, result_q, result_d, addend;
  logic [WIDTH:0]     acc_q, acc_d, sum, carry;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d, accept, sign_a, sign_b;
  logic [2*WIDTH-1:0] p, pn;
  assign addend = lo_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder u_fa (
      .a_i(acc_q[i]),
      .b_i(addend[i]),
      .c_i(carry[i]),
      .s_o(sum[i]),
      .c_o(carry[i+1])
    );
  end
  // The carry out of the low WIDTH bits becomes acc bit WIDTH; MULHU needs it.
  assign sum[WIDTH] = acc_q[WIDTH] ^ carry[WIDTH];
  assign accept = start_i && (state_q == IDLE || state_q == DONE);
  assign sign_a = a_i[WIDTH-1] && (op_i == 2'b01 || op_i == 2'b10);
  assign sign_b = b_i[WIDTH-1] && (op_i == 2'b01);
  assign p  = {acc_q[WIDTH-1:0], lo_q};
  assign pn = neg_q ? -p : p;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      op_d    = op_i;
      mcand_d = sign_a ? -a_i : a_i;
      lo_d    = sign_b ? -b_i : b_i;
      neg_d   = sign_a ^ sign_b;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      {acc_d, lo_d} = {sum, lo_q} >> 1;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
    end else if (state_q == FIX) begin
      result_d = (op_q == 2'b00) ? pn[WIDTH-1:0] : pn[2*WIDTH-1:WIDTH];
      state_d  = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end
  assign result_o = result_q;
  assign busy_o   = (state_q == CALC) || (state_q == FIX);
  assign done_o   = (state_q == DONE);
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: random and directed checks of mul_unit against a 64-bit arithmetic model.
module tb_mul_unit;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0, result_o;
  logic        busy_o, done_o;
  int checks = 0, errors = 0;
  int m_cnt = 0;
  logic [31:0] m_pend = '0, m_result = '0;

  mul_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .result_o(result_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ea, eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    eb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p = 64'(ea * eb);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Model: m_cnt counts edges since acceptance; 1..33 busy, 34 is the done cycle.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_cnt = 0;
      m_result = '0;
    end else if (start_i && (m_cnt == 0 || m_cnt == 34)) begin
      m_cnt = 1;
      m_pend = exp_fn(op_i, a_i, b_i);
    end else if (m_cnt == 33) begin
      m_cnt = 34;
      m_result = m_pend;
    end else if (m_cnt == 34) begin
      m_cnt = 0;
    end else if (m_cnt != 0) begin
      m_cnt++;
    end
  end

  always @(negedge clk_i) begin
    chk("busy_cycle", {31'b0, busy_o}, {31'b0, m_cnt >= 1 && m_cnt <= 33});
    chk("done_cycle", {31'b0, done_o}, {31'b0, m_cnt == 34});
    chk("result_cycle", result_o, m_result);
  end

  task automatic wait_done(input string n);
    int i;
    for (i = 0; i < 60 && !done_o; i++) @(negedge clk_i);
    if (!done_o) chk({n, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string n, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk_i);
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
    wait_done(n);
    chk(n, result_o, exp);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 4)] : 32'($urandom);
  endfunction

  initial begin
    int n;
    logic [1:0] op;
    logic [31:0] a, b;
    chk("model_mul", exp_fn(2'b00, 32'd7, 32'd6), 32'h0000_002A);
    chk("model_mul_neg", exp_fn(2'b00, 32'hFFFF_FFFD, 32'd5), 32'hFFFF_FFF1);
    chk("model_mulh_neg", exp_fn(2'b01, 32'hFFFF_FFFD, 32'd5), 32'hFFFF_FFFF);
    chk("model_mulhu_max", exp_fn(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    repeat (3) @(negedge clk_i);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_done", {31'b0, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    rst_i = 1'b0;
    // Directed: first op timed exactly, then test-plan vectors.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd7; b_i = 32'd6;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 60) begin @(negedge clk_i); n++; end
    chk("latency_first", n, 34);
    chk("mul_7x6", result_o, 32'h2A);
    run_op("mul_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    run_op("mulh_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    run_op("mulh_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_maxmax", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_zero", 2'b01, 32'h0, 32'hFFFF_FFFB, 32'h0);
    // Start during busy is ignored.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd7; b_i = 32'd6;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b11; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("ignored_start");
    chk("ignored_start", result_o, 32'h2A);
    // Start held in DONE: back-to-back acceptance.
    start_i = 1'b1; op_i = 2'b11; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 60) begin @(negedge clk_i); n++; end
    chk("b2b_latency", n, 34);
    chk("b2b_result", result_o, 32'hFFFF_FFFE);
    // Asynchronous reset mid-operation.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd100; b_i = 32'd3;
    repeat (16) @(posedge clk_i);
    start_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_done", {31'b0, done_o}, 32'd0);
    chk("arst_result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    n = 0;
    repeat (45) begin @(negedge clk_i); if (done_o) n++; end
    chk("arst_no_done", n, 0);
    run_op("after_reset", 2'b00, 32'd7, 32'd6, 32'h2A);
    // Random operations against the model.
    repeat (150) begin
      op = 2'($urandom);
      a = pick();
      b = pick();
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      run_op("random", op, a, b, exp_fn(op, a, b));
    end
    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Multi-cycle RV32M multiplier in the EX stage, beside the ALU. Handles MUL, MULH, MULHSU and MULHU.
- Uses radix-2 shift-add: one partial-product addition per clock, through a WIDTH-bit ripple-carry adder built from the team's full_adder cells.
- The hazard unit stalls the pipeline while busy_o is high. The writeback mux takes result_o when done_o pulses.

Parameters:
- WIDTH, 32, operand and result width; also the number of CALC iterations.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  request; accepted only in IDLE or DONE
- op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- a_i  input  WIDTH  rs1 operand
- b_i  input  WIDTH  rs2 operand
- result_o  output  WIDTH  registered result; held until the next completion or reset
- busy_o  output  1  high in CALC and FIX
- done_o  output  1  one-cycle pulse in DONE

Behaviour:
- Reset, asynchronous and active-high: state goes to IDLE immediately; result_o, busy_o, done_o and all internal registers go to 0.
  - Reset mid-operation aborts the operation with no done_o.
- States: IDLE, CALC, FIX, DONE.
- IDLE: when start_i=1 at the rising edge, the operation is accepted. On that edge:
  - latch op_i;
  - sign_a = a_i[W-1] when op is MULH or MULHSU, else 0;
  - sign_b = b_i[W-1] when op is MULH, else 0;
  - mcand = |a| if sign_a, else a_i; plier = |b| if sign_b, else b_i; magnitudes are taken by two's-complement negation;
  - neg = sign_a XOR sign_b; acc_hi (WIDTH+1 bits) = 0; lo = plier; count = 0; go to CALC.
  - a_i, b_i and op_i are ignored at every other time.
- CALC, one iteration per edge:
  - sum = acc_hi + (lo[0] ? mcand : 0), WIDTH+1 bits, carry-in 0;
  - {acc_hi, lo} <= {sum, lo} >> 1;
  - count increments; after the WIDTH-th iteration (count = WIDTH-1 on that edge), go to FIX.
- FIX, one edge:
  - P = {acc_hi[W-1:0], lo}, 2*WIDTH bits;
  - if neg, P = two's-complement negation of P;
  - result_o <= P[W-1:0] for MUL, else P[2W-1:W];
  - go to DONE.
- DONE, one cycle:
  - done_o = 1 and busy_o = 0;
  - if start_i=1, accept a new operation exactly as in IDLE and go to CALC (back-to-back); otherwise go to IDLE.
- start_i while busy_o=1: ignored, no queuing.
- Latency: accept edge E0, CALC edges E1..E32, FIX edge E33, done_o high from E33 to E34. This is 34 clocks from accept to the done_o pulse, with WIDTH=32.
- MUL: the low word is sign-independent. Operands are still conditioned as above; op 00 uses sign_a = sign_b = 0.
- Boundary cases:
  - a = 0x80000000 signed: the magnitude 0x80000000 fits in unsigned WIDTH bits.
  - neg with P = 0: negation gives 0, never all-ones.
- The accumulator carry (bit W of sum) must be kept in acc_hi; dropping it corrupts MULHU.

Test Plan:
- MUL a=7, b=6, start at E0 -> busy_o high E0..E33, done_o pulse after E33, result_o=0x0000002A; no done_o at any other cycle.
- MUL a=0xFFFFFFFD (-3), b=5 -> 0xFFFFFFF1. The same operands with MULH -> 0xFFFFFFFF.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> 0xFFFFFFFF. MULH a=0, b=0xFFFFFFFB -> 0x00000000.
- Pulse start_i with different operands at E10 of a running MUL 7*6 -> ignored; result 0x2A. With start_i held in DONE -> next op accepted, next done_o exactly 34 clocks later.
- Assert rst_i asynchronously mid-edge at E15 -> busy_o, done_o and result_o go to 0 immediately. No done_o follows. A fresh start after release completes normally.
